// File: rtl/apes_acq_seq.sv
// rtl/apes_acq_seq.sv - APES acquisition sequencer: clear, timed collection, per-channel readout, framing.
module apes_acq_seq #(
  parameter int NCH   = 4,
  parameter int CNT_W = 24,
  parameter int TO_W  = 16
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             mode_cont,
  input  logic             abort,
  input  logic [CNT_W-1:0] coll_len,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             collect_done,
  input  logic [NCH-1:0]   rd_done,
  output logic             cnt_clr,
  output logic             cnt_start,
  output logic [NCH-1:0]   rd_en,
  output logic             busy,
  output logic             frame_done,
  output logic             timeout_err,
  output logic [15:0]      frame_cnt
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COLLECT, S_READ, S_NEXT, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len_q, len_nxt;
  logic [CNT_W-1:0] coll_cnt, coll_cnt_nxt;
  logic [NCH-1:0]   mask_q, mask_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic [CH_W-1:0]  ch_q, ch_nxt;
  logic             cnt_clr_nxt, cnt_start_nxt, busy_nxt, frame_done_nxt, timeout_err_nxt;
  logic [NCH-1:0]   rd_en_nxt;
  logic [15:0]      frame_cnt_nxt;

  logic             coll_end, rd_hit, to_hit;
  logic             first_found, next_found;
  logic [CH_W-1:0]  first_ch, next_ch;

  // Lowest set mask bit at or above index 'from'; MSB of the result flags a hit.
  function automatic logic [CH_W:0] find_ch(input logic [NCH-1:0] m, input int from);
    logic [CH_W:0] res;
    res = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && i >= from) res = {1'b1, CH_W'(i)};
    end
    return res;
  endfunction

  assign coll_end = (coll_cnt == len_q - CNT_W'(1)) || collect_done;
  assign rd_hit   = rd_done[ch_q];
  assign to_hit   = &to_cnt;
  assign {first_found, first_ch} = find_ch(mask_q, 0);
  assign {next_found, next_ch}   = find_ch(mask_q, int'(ch_q) + 1);

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len_q       <= CNT_W'(1);
      coll_cnt    <= '0;
      mask_q      <= '0;
      to_cnt      <= '0;
      ch_q        <= '0;
      cnt_clr     <= 1'b0;
      cnt_start   <= 1'b0;
      rd_en       <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      len_q       <= len_nxt;
      coll_cnt    <= coll_cnt_nxt;
      mask_q      <= mask_nxt;
      to_cnt      <= to_cnt_nxt;
      ch_q        <= ch_nxt;
      cnt_clr     <= cnt_clr_nxt;
      cnt_start   <= cnt_start_nxt;
      rd_en       <= rd_en_nxt;
      busy        <= busy_nxt;
      frame_done  <= frame_done_nxt;
      timeout_err <= timeout_err_nxt;
      frame_cnt   <= frame_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state != S_IDLE && abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (arm) state_nxt = S_CLEAR;
        S_CLEAR:   state_nxt = S_COLLECT;
        S_COLLECT: if (coll_end) state_nxt = first_found ? S_READ : S_DONE;
        S_READ:    if (rd_hit || to_hit) state_nxt = S_NEXT;
        S_NEXT:    state_nxt = next_found ? S_READ : S_DONE;
        S_DONE:    state_nxt = mode_cont ? S_CLEAR : S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    len_nxt         = len_q;
    coll_cnt_nxt    = coll_cnt;
    mask_nxt        = mask_q;
    to_cnt_nxt      = to_cnt;
    ch_nxt          = ch_q;
    cnt_clr_nxt     = 1'b0;
    cnt_start_nxt   = cnt_start;
    rd_en_nxt       = rd_en;
    timeout_err_nxt = timeout_err;
    busy_nxt        = (state_nxt != S_IDLE);
    frame_done_nxt  = (state_nxt == S_DONE);
    frame_cnt_nxt   = (state_nxt == S_DONE) ? frame_cnt + 16'd1 : frame_cnt;
    if (state != S_IDLE && abort) begin
      cnt_start_nxt = 1'b0;
      rd_en_nxt     = '0;
      cnt_clr_nxt   = 1'b1;
    end else if ((state == S_IDLE && arm) || (state == S_DONE && mode_cont)) begin
      cnt_clr_nxt     = 1'b1;
      len_nxt         = (coll_len == '0) ? CNT_W'(1) : coll_len;
      mask_nxt        = ch_mask;
      timeout_err_nxt = 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          cnt_start_nxt = 1'b1;
          coll_cnt_nxt  = '0;
        end
        S_COLLECT: begin
          if (coll_end) begin
            cnt_start_nxt = 1'b0;
            if (first_found) begin
              rd_en_nxt           = '0;
              rd_en_nxt[first_ch] = 1'b1;
              ch_nxt              = first_ch;
              to_cnt_nxt          = TO_W'(1);
            end
          end else begin
            coll_cnt_nxt = coll_cnt + CNT_W'(1);
          end
        end
        S_READ: begin
          // to_cnt counts enabled cycles from 1, so a readout lasts at most all-ones cycles.
          if (rd_hit) begin
            rd_en_nxt = '0;
          end else if (to_hit) begin
            rd_en_nxt       = '0;
            timeout_err_nxt = 1'b1;
          end else begin
            to_cnt_nxt = to_cnt + TO_W'(1);
          end
        end
        S_NEXT: begin
          if (next_found) begin
            rd_en_nxt          = '0;
            rd_en_nxt[next_ch] = 1'b1;
            ch_nxt             = next_ch;
            to_cnt_nxt         = TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apes_acq_seq.sv
// tb/tb_apes_acq_seq.sv - directed self-checking bench for apes_acq_seq.
module tb_apes_acq_seq;

  localparam int NCH = 4;
  localparam int CNT_W = 24;
  localparam int TO_W = 4;

  logic             clk50 = 1'b0;
  logic             rst_n;
  logic             arm, mode_cont, abort, collect_done;
  logic [CNT_W-1:0] coll_len;
  logic [NCH-1:0]   ch_mask, rd_done;
  logic             cnt_clr, cnt_start, busy, frame_done, timeout_err;
  logic [NCH-1:0]   rd_en;
  logic [15:0]      frame_cnt;

  int passed = 0;
  int total = 0;

  logic           clr_log[0:63];
  logic           start_log[0:63];
  logic           busy_log[0:63];
  logic           done_log[0:63];
  logic           te_log[0:63];
  logic [NCH-1:0] en_log[0:63];
  logic [15:0]    fc_log[0:63];

  apes_acq_seq #(.NCH(NCH), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk50(clk50), .rst_n(rst_n), .arm(arm), .mode_cont(mode_cont), .abort(abort),
    .coll_len(coll_len), .ch_mask(ch_mask), .collect_done(collect_done), .rd_done(rd_done),
    .cnt_clr(cnt_clr), .cnt_start(cnt_start), .rd_en(rd_en), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  always #10 clk50 = ~clk50;

  // Cycle c is observed at the negedge after the c-th posedge following arm; rd_done is raised d cycles into each enable.
  task automatic run(input int ncyc, input int d, input int cd_at, input int abort_at, input int mc_off_at);
    int en_cnt;
    en_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk50);
      clr_log[c] = cnt_clr; start_log[c] = cnt_start; en_log[c] = rd_en;
      busy_log[c] = busy; done_log[c] = frame_done; te_log[c] = timeout_err; fc_log[c] = frame_cnt;
      arm = 1'b0;
      collect_done = (c == cd_at);
      abort = (c == abort_at);
      if (c == mc_off_at) mode_cont = 1'b0;
      if (rd_en != '0) en_cnt++; else en_cnt = 0;
      rd_done = (d > 0 && en_cnt >= d) ? rd_en : '0;
    end
    collect_done = 1'b0; abort = 1'b0; rd_done = '0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; arm = 1'b0; mode_cont = 1'b0; abort = 1'b0; collect_done = 1'b0;
    coll_len = '0; ch_mask = '0; rd_done = '0;
    repeat (2) @(negedge clk50);
    total++;
    if ({cnt_clr, cnt_start, rd_en, busy, frame_done, timeout_err, frame_cnt} !== '0)
      $display("FAIL reset_outputs: got clr=%b start=%b en=%b busy=%b fd=%b te=%b fc=%0h, expected all 0",
               cnt_clr, cnt_start, rd_en, busy, frame_done, timeout_err, frame_cnt);
    else passed++;
    rst_n = 1'b1;
    run(4, 0, -1, -1, -1);
    n = 0;
    for (int c = 0; c < 4; c++) n += busy_log[c] + clr_log[c];
    total++;
    if (n != 0) $display("FAIL reset_idle: got %0d busy/clr cycles, expected 0", n);
    else passed++;
  endtask

  task automatic test_single_shot();
    int n_start, n_en, n_done, n_busy;
    coll_len = 24'd10; ch_mask = 4'b0101; arm = 1'b1;
    run(24, 3, -1, -1, -1);
    n_start = 0; n_en = 0; n_done = 0; n_busy = 0;
    for (int c = 0; c < 24; c++) begin
      n_start += start_log[c]; n_en += (en_log[c] != '0); n_done += done_log[c]; n_busy += busy_log[c];
    end
    total++;
    if (clr_log[0] !== 1'b1 || clr_log[1] !== 1'b0)
      $display("FAIL ss_clr: got %b%b, expected 10", clr_log[0], clr_log[1]);
    else passed++;
    total++;
    if (n_start != 10 || start_log[1] !== 1'b1 || start_log[10] !== 1'b1)
      $display("FAIL ss_start: got %0d cycles, expected 10 from cycle 1", n_start);
    else passed++;
    total++;
    if (en_log[11] !== 4'b0001 || en_log[13] !== 4'b0001 || en_log[14] !== 4'b0000 ||
        en_log[15] !== 4'b0100 || en_log[17] !== 4'b0100 || n_en != 6)
      $display("FAIL ss_rd_en: got %b %b %b %b %b n=%0d, expected 0001 0001 0000 0100 0100 n=6",
               en_log[11], en_log[13], en_log[14], en_log[15], en_log[17], n_en);
    else passed++;
    total++;
    if (n_done != 1 || done_log[19] !== 1'b1)
      $display("FAIL ss_frame_done: got %0d pulses at19=%b, expected 1 at cycle 19", n_done, done_log[19]);
    else passed++;
    total++;
    if (n_busy != 20) $display("FAIL ss_busy: got %0d cycles, expected 20", n_busy);
    else passed++;
    total++;
    if (frame_cnt !== 16'd1 || timeout_err !== 1'b0)
      $display("FAIL ss_status: got fc=%0d te=%b, expected fc=1 te=0", frame_cnt, timeout_err);
    else passed++;
  endtask

  task automatic test_collect_done();
    int n_start;
    coll_len = 24'd100; ch_mask = 4'b1000; arm = 1'b1;
    run(14, 2, 5, -1, -1);
    n_start = 0;
    for (int c = 0; c < 14; c++) n_start += start_log[c];
    total++;
    if (n_start != 5 || start_log[5] !== 1'b1 || start_log[6] !== 1'b0)
      $display("FAIL cd_start: got %0d cycles, expected 5", n_start);
    else passed++;
    total++;
    if (en_log[6] !== 4'b1000 || en_log[7] !== 4'b1000 || en_log[8] !== 4'b0000 || done_log[9] !== 1'b1)
      $display("FAIL cd_readout: got en6=%b en7=%b en8=%b fd9=%b, expected 1000 1000 0000 1",
               en_log[6], en_log[7], en_log[8], done_log[9]);
    else passed++;
    total++;
    if (frame_cnt !== 16'd2) $display("FAIL cd_frame_cnt: got %0d, expected 2", frame_cnt);
    else passed++;
  endtask

  task automatic test_timeout();
    int n_en;
    coll_len = 24'd1; ch_mask = 4'b0010; arm = 1'b1;
    run(22, 0, -1, -1, -1);
    n_en = 0;
    for (int c = 0; c < 22; c++) n_en += (en_log[c] != '0);
    total++;
    if (n_en != 15 || en_log[2] !== 4'b0010 || en_log[16] !== 4'b0010 || en_log[17] !== 4'b0000)
      $display("FAIL to_rd_en: got %0d cycles, expected 15 of 0010 from cycle 2", n_en);
    else passed++;
    total++;
    if (te_log[16] !== 1'b0 || te_log[17] !== 1'b1 || done_log[18] !== 1'b1)
      $display("FAIL to_err: got te16=%b te17=%b fd18=%b, expected 0 1 1", te_log[16], te_log[17], done_log[18]);
    else passed++;
    run(5, 0, -1, -1, -1);
    total++;
    if (timeout_err !== 1'b1 || frame_cnt !== 16'd3)
      $display("FAIL to_sticky: got te=%b fc=%0d, expected te=1 fc=3", timeout_err, frame_cnt);
    else passed++;
  endtask

  task automatic test_abort();
    int n_done;
    coll_len = 24'd2; ch_mask = 4'b0100; arm = 1'b1;
    run(10, 0, -1, 4, -1);
    n_done = 0;
    for (int c = 0; c < 10; c++) n_done += done_log[c];
    total++;
    if (te_log[0] !== 1'b0) $display("FAIL ab_err_cleared: got %b, expected 0", te_log[0]);
    else passed++;
    total++;
    if (en_log[4] !== 4'b0100 || en_log[5] !== 4'b0000 || clr_log[5] !== 1'b1 ||
        clr_log[6] !== 1'b0 || busy_log[5] !== 1'b0)
      $display("FAIL ab_response: got en4=%b en5=%b clr5=%b clr6=%b busy5=%b, expected 0100 0000 1 0 0",
               en_log[4], en_log[5], clr_log[5], clr_log[6], busy_log[5]);
    else passed++;
    total++;
    if (n_done != 0 || frame_cnt !== 16'd3)
      $display("FAIL ab_no_frame: got %0d pulses fc=%0d, expected 0 and 3", n_done, frame_cnt);
    else passed++;
  endtask

  task automatic test_continuous();
    int n_done;
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk50);
    release dut.frame_cnt;
    coll_len = 24'd0; ch_mask = 4'b0000; mode_cont = 1'b1; arm = 1'b1;
    run(14, 0, -1, -1, 6);
    n_done = 0;
    for (int c = 0; c < 14; c++) n_done += done_log[c];
    total++;
    if (done_log[2] !== 1'b1 || done_log[5] !== 1'b1 || done_log[8] !== 1'b1 || n_done != 3)
      $display("FAIL ct_period: got %0d pulses (c2=%b c5=%b c8=%b), expected 3 at 2,5,8",
               n_done, done_log[2], done_log[5], done_log[8]);
    else passed++;
    total++;
    if (fc_log[2] !== 16'h0000 || fc_log[5] !== 16'h0001 || fc_log[8] !== 16'h0002)
      $display("FAIL ct_wrap: got %0h %0h %0h, expected 0 1 2", fc_log[2], fc_log[5], fc_log[8]);
    else passed++;
    total++;
    if (clr_log[3] !== 1'b1 || clr_log[6] !== 1'b1 || clr_log[9] !== 1'b0 || busy_log[9] !== 1'b0)
      $display("FAIL ct_rearm: got clr3=%b clr6=%b clr9=%b busy9=%b, expected 1 1 0 0",
               clr_log[3], clr_log[6], clr_log[9], busy_log[9]);
    else passed++;
  endtask

  task automatic test_async_reset();
    int n;
    coll_len = 24'd50; ch_mask = 4'b0001; arm = 1'b1;
    run(3, 0, -1, -1, -1);
    total++;
    if (start_log[2] !== 1'b1) $display("FAIL rst_precond: got start=%b, expected 1", start_log[2]);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({cnt_clr, cnt_start, rd_en, busy, frame_done, timeout_err, frame_cnt} !== '0)
      $display("FAIL rst_async: got clr=%b start=%b en=%b busy=%b fd=%b te=%b fc=%0h, expected all 0",
               cnt_clr, cnt_start, rd_en, busy, frame_done, timeout_err, frame_cnt);
    else passed++;
    repeat (2) @(negedge clk50);
    rst_n = 1'b1;
    run(6, 0, -1, -1, -1);
    n = 0;
    for (int c = 0; c < 6; c++) n += busy_log[c] + clr_log[c] + start_log[c];
    total++;
    if (n != 0) $display("FAIL rst_idle_after: got %0d active cycles, expected 0", n);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_collect_done();
    test_timeout();
    test_abort();
    test_continuous();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
